// File: rtl/id_scoreboard_pkg.sv
// Shared CPU constants for the decode-stage register scoreboard: default sizes and the
// forwarding-select encoding (0 = regfile, k+1 = bypass stage k).
package id_scoreboard_pkg;

  localparam int unsigned NREG_DEF  = 32;
  localparam int unsigned NSTG_DEF  = 3;
  localparam int unsigned CNT_W_DEF = 2;

  localparam int unsigned FWD_SEL_RF = 0;

  function automatic int fwd_sel_stage(input int stage);
    return stage + 1;
  endfunction

endpackage

// File: rtl/id_scoreboard_if.sv
// Decode/bypass/writeback signals seen by the scoreboard; master drives the pipeline side.
interface id_scoreboard_if
  import id_scoreboard_pkg::*;
#(
  parameter int unsigned NREG = NREG_DEF,
  parameter int unsigned NSTG = NSTG_DEF
);
  localparam int unsigned AW = $clog2(NREG);
  localparam int unsigned SW = $clog2(NSTG + 1);

  logic               ds_valid;
  logic [AW-1:0]      ds_raddr1;
  logic [AW-1:0]      ds_raddr2;
  logic               ds_need_r1;
  logic               ds_need_r2;
  logic               ds_rf_we;
  logic [AW-1:0]      ds_rf_waddr;
  logic               es_allowin;
  logic [NSTG-1:0]    stg_rf_we;
  logic [NSTG-1:0]    stg_data_ok;
  logic [NSTG*AW-1:0] stg_rf_waddr;
  logic               ws_retire;
  logic [AW-1:0]      ws_rf_waddr;
  logic               flush;
  logic               ds_ready_go;
  logic [SW-1:0]      fwd_sel1;
  logic [SW-1:0]      fwd_sel2;
  logic [NREG-1:0]    pending;
  logic               sb_err;

  modport master (
    output ds_valid, ds_raddr1, ds_raddr2, ds_need_r1, ds_need_r2, ds_rf_we, ds_rf_waddr,
           es_allowin, stg_rf_we, stg_data_ok, stg_rf_waddr, ws_retire, ws_rf_waddr, flush,
    input  ds_ready_go, fwd_sel1, fwd_sel2, pending, sb_err
  );

  modport slave (
    input  ds_valid, ds_raddr1, ds_raddr2, ds_need_r1, ds_need_r2, ds_rf_we, ds_rf_waddr,
           es_allowin, stg_rf_we, stg_data_ok, stg_rf_waddr, ws_retire, ws_rf_waddr, flush,
    output ds_ready_go, fwd_sel1, fwd_sel2, pending, sb_err
  );

endinterface

// File: rtl/id_scoreboard_sb_counter.sv
// One register's outstanding-write counter: saturating up/down with flush clear; reports
// an illegal step (decrement at zero, increment at max) as a one-cycle error pulse.
module sb_counter #(
  parameter int unsigned CNT_W = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_inc,
  input  logic i_dec,
  input  logic i_flush,
  output logic o_nz,
  output logic o_sat,
  output logic o_err
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_err;

  always_comb begin
    w_cnt_nxt = r_cnt;
    w_err     = 1'b0;
    if (i_flush) begin
      w_cnt_nxt = '0;
    end else if (i_inc && !i_dec) begin
      if (r_cnt != '1) w_cnt_nxt = r_cnt + CNT_W'(1);
      else             w_err     = 1'b1;
    end else if (i_dec && !i_inc) begin
      if (r_cnt != '0) w_cnt_nxt = r_cnt - CNT_W'(1);
      else             w_err     = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_cnt <= '0;
    else       r_cnt <= w_cnt_nxt;
  end

  assign o_nz  = (r_cnt != '0);
  assign o_sat = (r_cnt == '1);
  assign o_err = w_err;

endmodule

// File: rtl/id_scoreboard.sv
// Decode-stage scoreboard: per-register pending-write counters, bypass selection
// (youngest matching stage wins) and the decode issue/stall decision.
module id_scoreboard
  import id_scoreboard_pkg::*;
#(
  parameter int unsigned NREG  = NREG_DEF,
  parameter int unsigned NSTG  = NSTG_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input logic             clk,
  input logic             reset,
  id_scoreboard_if.slave  sb
);

  localparam int unsigned AW = $clog2(NREG);
  localparam int unsigned SW = $clog2(NSTG + 1);

  logic            w_issue;
  logic [NREG-1:0] w_inc;
  logic [NREG-1:0] w_dec;
  logic [NREG-1:0] w_nz;
  logic [NREG-1:0] w_sat;
  logic [NREG-1:0] w_err;
  logic [SW-1:0]   w_fwd1;
  logic [SW-1:0]   w_fwd2;
  logic            w_hit1;
  logic            w_hit2;
  logic            w_ok1;
  logic            w_ok2;
  logic            w_stall1;
  logic            w_stall2;
  logic            w_stall_wr;
  logic            r_sb_err;

  // Walk oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    w_fwd1 = SW'(FWD_SEL_RF);
    w_fwd2 = SW'(FWD_SEL_RF);
    w_hit1 = 1'b0;
    w_hit2 = 1'b0;
    w_ok1  = 1'b1;
    w_ok2  = 1'b1;
    for (int k = NSTG - 1; k >= 0; k--) begin
      if (sb.stg_rf_we[k] && sb.stg_rf_waddr[k*AW +: AW] == sb.ds_raddr1 &&
          sb.ds_raddr1 != '0) begin
        w_fwd1 = SW'(fwd_sel_stage(k));
        w_hit1 = 1'b1;
        w_ok1  = sb.stg_data_ok[k];
      end
      if (sb.stg_rf_we[k] && sb.stg_rf_waddr[k*AW +: AW] == sb.ds_raddr2 &&
          sb.ds_raddr2 != '0) begin
        w_fwd2 = SW'(fwd_sel_stage(k));
        w_hit2 = 1'b1;
        w_ok2  = sb.stg_data_ok[k];
      end
    end
  end

  // A pending writer with no stage match lives in a unit the bypass network cannot see.
  always_comb begin
    w_stall1   = sb.ds_need_r1 && (sb.ds_raddr1 != '0) &&
                 (w_hit1 ? !w_ok1 : w_nz[sb.ds_raddr1]);
    w_stall2   = sb.ds_need_r2 && (sb.ds_raddr2 != '0) &&
                 (w_hit2 ? !w_ok2 : w_nz[sb.ds_raddr2]);
    w_stall_wr = sb.ds_rf_we && (sb.ds_rf_waddr != '0) && w_sat[sb.ds_rf_waddr];
  end

  assign sb.ds_ready_go = !(sb.ds_valid && (w_stall1 || w_stall2 || w_stall_wr));
  assign w_issue        = sb.ds_valid && sb.ds_ready_go && sb.es_allowin;

  assign w_inc[0] = 1'b0;
  assign w_dec[0] = 1'b0;
  assign w_nz[0]  = 1'b0;
  assign w_sat[0] = 1'b0;
  assign w_err[0] = 1'b0;

  for (genvar r = 1; r < NREG; r++) begin : g_cnt
    assign w_inc[r] = w_issue && sb.ds_rf_we && (sb.ds_rf_waddr == AW'(r));
    assign w_dec[r] = sb.ws_retire && (sb.ws_rf_waddr == AW'(r));

    sb_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk     (clk),
      .reset   (reset),
      .i_inc   (w_inc[r]),
      .i_dec   (w_dec[r]),
      .i_flush (sb.flush),
      .o_nz    (w_nz[r]),
      .o_sat   (w_sat[r]),
      .o_err   (w_err[r])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_sb_err <= 1'b0;
    else       r_sb_err <= r_sb_err | (|w_err);
  end

  assign sb.fwd_sel1 = w_fwd1;
  assign sb.fwd_sel2 = w_fwd2;
  assign sb.pending  = w_nz;
  assign sb.sb_err   = r_sb_err;

endmodule

// File: tb/tb_id_scoreboard.sv
// Directed bench for id_scoreboard: forwarding, load-use, saturation, flush, reset.
module tb_id_scoreboard;

  localparam int unsigned NREG = 32;
  localparam int unsigned NSTG = 3;
  localparam int unsigned AW   = 5;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  id_scoreboard_if #(.NREG(NREG), .NSTG(NSTG)) bus ();

  id_scoreboard #(
    .NREG  (NREG),
    .NSTG  (NSTG),
    .CNT_W (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .sb    (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic idle();
    bus.ds_valid     = 1'b0;
    bus.ds_raddr1    = '0;
    bus.ds_raddr2    = '0;
    bus.ds_need_r1   = 1'b0;
    bus.ds_need_r2   = 1'b0;
    bus.ds_rf_we     = 1'b0;
    bus.ds_rf_waddr  = '0;
    bus.es_allowin   = 1'b1;
    bus.stg_rf_we    = '0;
    bus.stg_data_ok  = '0;
    bus.stg_rf_waddr = '0;
    bus.ws_retire    = 1'b0;
    bus.ws_rf_waddr  = '0;
    bus.flush        = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic issue_write(input logic [AW-1:0] r);
    idle();
    bus.ds_valid    = 1'b1;
    bus.ds_rf_we    = 1'b1;
    bus.ds_rf_waddr = r;
    tick();
    idle();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    tick();
    #1;
    checks++;
    if (bus.pending !== 32'h0) begin
      $display("FAIL reset_pending: got %h expected %h", bus.pending, 32'h0); errors++;
    end
    checks++;
    if (bus.ds_ready_go !== 1'b1) begin
      $display("FAIL reset_ready: got %b expected 1", bus.ds_ready_go); errors++;
    end
    checks++;
    if (bus.fwd_sel1 !== 2'd0 || bus.fwd_sel2 !== 2'd0) begin
      $display("FAIL reset_fwd: got %0d/%0d expected 0/0", bus.fwd_sel1, bus.fwd_sel2);
      errors++;
    end
    checks++;
    if (bus.sb_err !== 1'b0) begin
      $display("FAIL reset_err: got %b expected 0", bus.sb_err); errors++;
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_forward();
    issue_write(5'd5);
    #1;
    checks++;
    if (bus.pending !== 32'h0000_0020) begin
      $display("FAIL fwd_pending: got %h expected %h", bus.pending, 32'h20); errors++;
    end
    bus.stg_rf_we    = 3'b001;
    bus.stg_data_ok  = 3'b001;
    bus.stg_rf_waddr = {5'd0, 5'd0, 5'd5};
    bus.ds_valid     = 1'b1;
    bus.ds_need_r1   = 1'b1;
    bus.ds_raddr1    = 5'd5;
    #1;
    checks++;
    if (bus.ds_ready_go !== 1'b1 || bus.fwd_sel1 !== 2'd1) begin
      $display("FAIL fwd_r5: got ready=%b sel1=%0d expected ready=1 sel1=1",
               bus.ds_ready_go, bus.fwd_sel1);
      errors++;
    end
    tick();
    idle();
    bus.ws_retire   = 1'b1;
    bus.ws_rf_waddr = 5'd5;
    tick();
    idle();
    #1;
    checks++;
    if (bus.pending !== 32'h0) begin
      $display("FAIL fwd_retire: got %h expected %h", bus.pending, 32'h0); errors++;
    end
  endtask

  task automatic test_load_use();
    issue_write(5'd7);
    bus.stg_rf_we    = 3'b001;
    bus.stg_data_ok  = 3'b000;
    bus.stg_rf_waddr = {5'd0, 5'd0, 5'd7};
    bus.ds_valid     = 1'b1;
    bus.ds_need_r2   = 1'b1;
    bus.ds_raddr2    = 5'd7;
    #1;
    checks++;
    if (bus.ds_ready_go !== 1'b0) begin
      $display("FAIL load_use_stall: got %b expected 0", bus.ds_ready_go); errors++;
    end
    tick();
    bus.stg_rf_we    = 3'b010;
    bus.stg_data_ok  = 3'b010;
    bus.stg_rf_waddr = {5'd0, 5'd7, 5'd0};
    #1;
    checks++;
    if (bus.ds_ready_go !== 1'b1 || bus.fwd_sel2 !== 2'd2) begin
      $display("FAIL load_use_go: got ready=%b sel2=%0d expected ready=1 sel2=2",
               bus.ds_ready_go, bus.fwd_sel2);
      errors++;
    end
    tick();
    idle();
    bus.ws_retire   = 1'b1;
    bus.ws_rf_waddr = 5'd7;
    tick();
    idle();
  endtask

  task automatic test_unbypassed();
    issue_write(5'd6);
    bus.ds_valid   = 1'b1;
    bus.ds_need_r1 = 1'b1;
    bus.ds_raddr1  = 5'd6;
    #1;
    checks++;
    if (bus.ds_ready_go !== 1'b0) begin
      $display("FAIL unbyp_stall: got %b expected 0", bus.ds_ready_go); errors++;
    end
    bus.ds_valid = 1'b0;
    #1;
    checks++;
    if (bus.ds_ready_go !== 1'b1) begin
      $display("FAIL unbyp_invalid: got %b expected 1", bus.ds_ready_go); errors++;
    end
    bus.ds_valid   = 1'b1;
    bus.ds_need_r1 = 1'b0;
    #1;
    checks++;
    if (bus.ds_ready_go !== 1'b1) begin
      $display("FAIL unbyp_noneed: got %b expected 1", bus.ds_ready_go); errors++;
    end
    idle();
    bus.ws_retire   = 1'b1;
    bus.ws_rf_waddr = 5'd6;
    tick();
    idle();
  endtask

  task automatic test_saturate();
    idle();
    bus.ds_valid    = 1'b1;
    bus.ds_rf_we    = 1'b1;
    bus.ds_rf_waddr = 5'd3;
    tick();
    tick();
    tick();
    #1;
    checks++;
    if (bus.ds_ready_go !== 1'b0 || bus.pending !== 32'h0000_0008) begin
      $display("FAIL sat_stall: got ready=%b pend=%h expected ready=0 pend=%h",
               bus.ds_ready_go, bus.pending, 32'h8);
      errors++;
    end
    bus.ws_retire   = 1'b1;
    bus.ws_rf_waddr = 5'd3;
    tick();
    bus.ws_retire = 1'b0;
    #1;
    checks++;
    if (bus.ds_ready_go !== 1'b1) begin
      $display("FAIL sat_after_retire: got %b expected 1", bus.ds_ready_go); errors++;
    end
    tick();
    #1;
    checks++;
    if (bus.ds_ready_go !== 1'b0) begin
      $display("FAIL sat_refill: got %b expected 0", bus.ds_ready_go); errors++;
    end
    idle();
    bus.flush = 1'b1;
    tick();
    idle();
    #1;
    checks++;
    if (bus.pending !== 32'h0 || bus.sb_err !== 1'b0) begin
      $display("FAIL sat_flush: got pend=%h err=%b expected pend=0 err=0",
               bus.pending, bus.sb_err);
      errors++;
    end
  endtask

  task automatic test_flush();
    issue_write(5'd4);
    bus.ds_valid    = 1'b1;
    bus.ds_rf_we    = 1'b1;
    bus.ds_rf_waddr = 5'd4;
    bus.ws_retire   = 1'b1;
    bus.ws_rf_waddr = 5'd4;
    bus.flush       = 1'b1;
    tick();
    idle();
    #1;
    checks++;
    if (bus.pending !== 32'h0) begin
      $display("FAIL flush_pending: got %h expected %h", bus.pending, 32'h0); errors++;
    end
    bus.ws_retire   = 1'b1;
    bus.ws_rf_waddr = 5'd4;
    tick();
    idle();
    #1;
    checks++;
    if (bus.sb_err !== 1'b1) begin
      $display("FAIL flush_underflow: got %b expected 1", bus.sb_err); errors++;
    end
    tick();
    #1;
    checks++;
    if (bus.sb_err !== 1'b1) begin
      $display("FAIL err_sticky: got %b expected 1", bus.sb_err); errors++;
    end
  endtask

  task automatic test_youngest();
    idle();
    bus.stg_rf_we    = 3'b101;
    bus.stg_data_ok  = 3'b111;
    bus.stg_rf_waddr = {5'd9, 5'd0, 5'd9};
    bus.ds_valid     = 1'b1;
    bus.ds_need_r1   = 1'b1;
    bus.ds_raddr1    = 5'd9;
    #1;
    checks++;
    if (bus.fwd_sel1 !== 2'd1 || bus.ds_ready_go !== 1'b1) begin
      $display("FAIL youngest: got sel1=%0d ready=%b expected sel1=1 ready=1",
               bus.fwd_sel1, bus.ds_ready_go);
      errors++;
    end
    bus.stg_rf_we    = 3'b011;
    bus.stg_data_ok  = 3'b000;
    bus.stg_rf_waddr = {5'd0, 5'd0, 5'd0};
    bus.ds_raddr1    = 5'd0;
    bus.ds_need_r2   = 1'b1;
    bus.ds_raddr2    = 5'd0;
    bus.ds_rf_we     = 1'b1;
    bus.ds_rf_waddr  = 5'd0;
    #1;
    checks++;
    if (bus.fwd_sel1 !== 2'd0 || bus.fwd_sel2 !== 2'd0 || bus.ds_ready_go !== 1'b1) begin
      $display("FAIL r0_bypass: got sel=%0d/%0d ready=%b expected 0/0 ready=1",
               bus.fwd_sel1, bus.fwd_sel2, bus.ds_ready_go);
      errors++;
    end
    tick();
    idle();
    #1;
    checks++;
    if (bus.pending !== 32'h0) begin
      $display("FAIL r0_pending: got %h expected %h", bus.pending, 32'h0); errors++;
    end
  endtask

  task automatic test_reset_mid();
    reset = 1'b1;
    #1;
    reset = 1'b0;
    issue_write(5'd10);
    issue_write(5'd11);
    bus.ds_valid    = 1'b1;
    bus.ds_rf_we    = 1'b1;
    bus.ds_rf_waddr = 5'd10;
    bus.ds_need_r1  = 1'b1;
    bus.ds_raddr1   = 5'd11;
    #1;
    checks++;
    if (bus.ds_ready_go !== 1'b0 || bus.pending !== 32'h0000_0C00) begin
      $display("FAIL mid_before: got ready=%b pend=%h expected ready=0 pend=%h",
               bus.ds_ready_go, bus.pending, 32'hC00);
      errors++;
    end
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.pending !== 32'h0 || bus.ds_ready_go !== 1'b1 || bus.sb_err !== 1'b0) begin
      $display("FAIL mid_reset: got pend=%h ready=%b err=%b expected pend=0 ready=1 err=0",
               bus.pending, bus.ds_ready_go, bus.sb_err);
      errors++;
    end
    #1;
    reset = 1'b0;
    tick();
    idle();
    #1;
    checks++;
    if (bus.pending !== 32'h0000_0400) begin
      $display("FAIL mid_after: got %h expected %h", bus.pending, 32'h400); errors++;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    idle();
    test_reset();
    test_forward();
    test_load_use();
    test_unbypassed();
    test_saturate();
    test_flush();
    test_youngest();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
